// File: rtl/spi_aes_slave_if.sv
// spi_aes_slave_if: SPI pins plus AES-core handshake of spi_aes_slave.
interface spi_aes_slave_if;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic [1:0]   size;
  logic [1:0]   key_size;
  logic [127:0] msg;
  logic [255:0] key;
  logic         start;
  logic [127:0] result;
  logic         result_valid;
  logic         done;
  logic         frame_err;
  modport slave (
    input  sclk, cs, mosi, size, result, result_valid,
    output miso, msg, key, key_size, start, done, frame_err
  );
  modport master (
    output sclk, cs, mosi, size, result, result_valid,
    input  miso, msg, key, key_size, start, done, frame_err
  );
endinterface

// File: rtl/spi_aes_slave.sv
// spi_aes_slave: SPI slave collecting an AES message and key, handing them to the
// core and shifting the core's 128-bit result back out LSB first.
module spi_aes_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  spi_aes_slave_if.slave bus
);
  localparam int SS = SYNC_STAGES < 2 ? 2 : SYNC_STAGES;
  typedef enum logic [2:0] {IDLE, RX_MSG, RX_KEY, START, WAIT_CORE, TX, DONE} state_t;
  state_t         state_q, state_d;
  logic [SS-1:0]  sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic           sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [SS:0]    warm_q, warm_d;
  logic [8:0]     cnt_q, cnt_d;
  logic [127:0]   msg_q, msg_d, shift_q, shift_d;
  logic [255:0]   key_q, key_d;
  logic [1:0]     size_q, size_d;
  logic           miso_q, miso_d, start_q, start_d, done_q, done_d, err_q, err_d;
  logic           rose_q, rose_d;
  logic           ready, sclk_s, cs_s, mosi_s;
  logic           sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [8:0]     key_base, key_last, key_idx;
  // Edges are ignored until the synchronizers have flushed their reset values,
  // so a cs already low at reset release is not mistaken for a fresh frame.
  assign ready     = warm_q[SS];
  assign sclk_s    = sclk_sync_q[SS-1];
  assign cs_s      = cs_sync_q[SS-1];
  assign mosi_s    = mosi_sync_q[SS-1];
  assign sclk_rise = ready & sclk_s & ~sclk_prev_q;
  assign sclk_fall = ready & ~sclk_s & sclk_prev_q;
  assign cs_rise   = ready & cs_s & ~cs_prev_q;
  assign cs_fall   = ready & ~cs_s & cs_prev_q;
  assign key_base  = size_q == 2'b00 ? 9'd128 : size_q == 2'b01 ? 9'd64 : 9'd0;
  assign key_last  = size_q == 2'b00 ? 9'd127 : size_q == 2'b01 ? 9'd191 : 9'd255;
  assign key_idx   = key_base + cnt_q;
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SS-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SS-2:0], bus.cs};
    mosi_sync_d = {mosi_sync_q[SS-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    warm_d      = {warm_q[SS-1:0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    msg_d       = msg_q;
    key_d       = key_q;
    shift_d     = shift_q;
    size_d      = size_q;
    rose_d      = rose_q;
    err_d       = 1'b0;
    if (cs_rise && state_q inside {RX_MSG, RX_KEY, START, WAIT_CORE, TX}) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:
          if (cs_fall) begin
            if (bus.size == 2'b11) err_d = 1'b1;
            else begin
              state_d = RX_MSG;
              size_d  = bus.size;
              cnt_d   = '0;
              msg_d   = '0;
              key_d   = '0;
            end
          end
        RX_MSG:
          if (sclk_rise) begin
            msg_d[cnt_q[6:0]] = mosi_s;
            cnt_d   = cnt_q == 9'd127 ? 9'd0 : cnt_q + 9'd1;
            state_d = cnt_q == 9'd127 ? RX_KEY : RX_MSG;
          end
        RX_KEY:
          if (sclk_rise) begin
            key_d[key_idx[7:0]] = mosi_s;
            cnt_d   = cnt_q == key_last ? cnt_q : cnt_q + 9'd1;
            state_d = cnt_q == key_last ? START : RX_KEY;
          end
        START: state_d = WAIT_CORE;
        WAIT_CORE:
          if (bus.result_valid) begin
            shift_d = bus.result;
            cnt_d   = '0;
            rose_d  = 1'b0;
            state_d = TX;
          end
        TX: begin
          // A bit only retires once the master has sampled it on a rising edge.
          if (sclk_rise) rose_d = 1'b1;
          if (sclk_fall && rose_q) begin
            rose_d = 1'b0;
            if (cnt_q == 9'd127) state_d = DONE;
            else begin
              shift_d = shift_q >> 1;
              cnt_d   = cnt_q + 9'd1;
            end
          end
        end
        DONE: state_d = cs_rise ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
    miso_d  = state_d == TX ? shift_d[0] : 1'b0;
    start_d = state_d == START;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      msg_q       <= '0;
      key_q       <= '0;
      shift_q     <= '0;
      size_q      <= 2'b00;
      rose_q      <= 1'b0;
      miso_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      warm_q      <= warm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      shift_q     <= shift_d;
      size_q      <= size_d;
      rose_q      <= rose_d;
      miso_q      <= miso_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  assign bus.miso      = miso_q;
  assign bus.msg       = msg_q;
  assign bus.key       = key_q;
  assign bus.key_size  = size_q;
  assign bus.start     = start_q;
  assign bus.done      = done_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_spi_aes_slave.sv
// tb_spi_aes_slave: drives SPI frames into spi_aes_slave and checks captured
// message/key, start pulses, miso stream, done and frame_err against a model.
module tb_spi_aes_slave;
  localparam int HALF = 5;
  typedef struct {
    logic [1:0]   size;
    logic [127:0] msg;
    logic [255:0] key_in;
    logic [127:0] res;
    logic [255:0] exp_key;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [127:0] cap_msg = '0;
  logic [255:0] cap_key = '0;
  logic [1:0]   cap_ks = '0;
  vec_t tbl[6];
  always #5 clk = ~clk;
  spi_aes_slave_if bus();
  spi_aes_slave #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always @(posedge clk) begin
    if (bus.start) begin
      start_cnt <= start_cnt + 1;
      cap_msg   <= bus.msg;
      cap_key   <= bus.key;
      cap_ks    <= bus.key_size;
    end
    if (bus.frame_err) err_cnt <= err_cnt + 1;
  end
  function automatic int key_bits(input logic [1:0] s);
    return s == 2'd0 ? 128 : s == 2'd1 ? 192 : 256;
  endfunction
  // Only the first N key bits are sent; they land left-justified in the 256-bit key.
  function automatic logic [255:0] model_key(input logic [1:0] s, input logic [255:0] k);
    int n;
    logic [255:0] mask;
    n = key_bits(s);
    mask = n == 256 ? '1 : (256'd1 << n) - 256'd1;
    return (k & mask) << (256 - n);
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clk_bit(input logic mo, output logic mi);
    bus.mosi = mo;
    tick(HALF);
    mi = bus.miso;
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
  endtask
  task automatic run_frame(input vec_t v, input int stop_at);
    int s0, nk;
    logic mi;
    logic [127:0] got;
    nk = key_bits(v.size);
    s0 = start_cnt;
    got = '0;
    bus.size = v.size;
    bus.cs = 1'b0;
    tick(4);
    for (int i = 0; i < 128; i++) clk_bit(v.msg[i], mi);
    check("miso_idle_rx", 256'(bus.miso), 256'(0));
    for (int i = 0; i < nk; i++) begin
      if (i == nk - 1) check("start_early", 256'(start_cnt), 256'(s0));
      clk_bit(v.key_in[i], mi);
    end
    tick(4);
    check("start_pulse", 256'(start_cnt), 256'(s0 + 1));
    check("msg", 256'(cap_msg), 256'(v.msg));
    check("key", cap_key, v.exp_key);
    check("key_size", 256'(cap_ks), 256'(v.size));
    tick(3);
    bus.result = v.res;
    bus.result_valid = 1'b1;
    tick(1);
    bus.result_valid = 1'b0;
    bus.result = rnd128();
    tick(2);
    for (int i = 0; i < stop_at; i++) begin
      clk_bit(1'b0, mi);
      got[i] = mi;
    end
    if (stop_at == 128) begin
      tick(4);
      check("miso_data", 256'(got), 256'(v.res));
      check("done", 256'(bus.done), 256'(1));
      for (int i = 0; i < 3; i++) clk_bit(1'b1, mi);
      tick(4);
      check("done_extra_sclk", 256'(bus.done), 256'(1));
      check("miso_done", 256'(bus.miso), 256'(0));
      check("start_once", 256'(start_cnt), 256'(s0 + 1));
      bus.cs = 1'b1;
      tick(6);
      check("done_clear", 256'(bus.done), 256'(0));
    end else begin
      check("miso_partial", 256'(got), 256'(v.res & ((128'd1 << stop_at) - 128'd1)));
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int e0, s0;
    logic mi;
    tbl[0] = '{2'd0, 128'h3243f6a8885a308d313198a2e0370734,
               {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c}, rnd128(), '0};
    tbl[1] = '{2'd1, rnd128(), 256'h000102030405060708090a0b0c0d0e0f1011121314151617, rnd128(), '0};
    tbl[2] = '{2'd2, 128'h3243f6a8885a308d313198a2e0370734,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h3925841d02dc09fbdc118597196a0b32, '0};
    for (int i = 3; i < 6; i++)
      tbl[i] = '{2'($urandom_range(0, 2)), rnd128(), {rnd128(), rnd128()}, rnd128(), '0};
    for (int i = 0; i < 6; i++) tbl[i].exp_key = model_key(tbl[i].size, tbl[i].key_in);
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.size = 2'b00;
    bus.result = '0;
    bus.result_valid = 1'b0;
    tick(3);
    check("rst_miso", 256'(bus.miso), 256'(0));
    check("rst_done", 256'(bus.done), 256'(0));
    check("rst_start", 256'(bus.start), 256'(0));
    check("rst_err", 256'(bus.frame_err), 256'(0));
    check("rst_msg", 256'(bus.msg), 256'(0));
    check("rst_key", bus.key, 256'(0));
    rst_n = 1'b1;
    tick(6);
    for (int i = 0; i < 6; i++) run_frame(tbl[i], 128);
    e0 = err_cnt;
    s0 = start_cnt;
    bus.size = 2'b00;
    bus.cs = 1'b0;
    tick(4);
    for (int i = 0; i < 50; i++) clk_bit(1'($urandom), mi);
    bus.cs = 1'b1;
    tick(6);
    check("abort_err", 256'(err_cnt), 256'(e0 + 1));
    check("abort_nostart", 256'(start_cnt), 256'(s0));
    run_frame(tbl[0], 128);
    e0 = err_cnt;
    s0 = start_cnt;
    bus.size = 2'b11;
    bus.cs = 1'b0;
    tick(6);
    check("size11_err", 256'(err_cnt), 256'(e0 + 1));
    for (int i = 0; i < 20; i++) clk_bit(1'b1, mi);
    tick(4);
    check("size11_msg", 256'(bus.msg), 256'(tbl[0].msg));
    check("size11_nostart", 256'(start_cnt), 256'(s0));
    bus.cs = 1'b1;
    tick(6);
    check("size11_rise", 256'(err_cnt), 256'(e0 + 1));
    run_frame(tbl[2], 60);
    tick(HALF);
    check("tx_bit60", 256'(bus.miso), 256'(tbl[2].res[60]));
    rst_n = 1'b0;
    #1;
    check("rst_tx_miso", 256'(bus.miso), 256'(0));
    check("rst_tx_done", 256'(bus.done), 256'(0));
    check("rst_tx_msg", 256'(bus.msg), 256'(0));
    tick(2);
    rst_n = 1'b1;
    e0 = err_cnt;
    s0 = start_cnt;
    tick(8);
    bus.result = tbl[2].res | 128'd1;
    bus.result_valid = 1'b1;
    tick(1);
    bus.result_valid = 1'b0;
    tick(3);
    check("late_rv_miso", 256'(bus.miso), 256'(0));
    for (int i = 0; i < 5; i++) begin
      clk_bit(1'b1, mi);
      check("late_rv_miso_bit", 256'(mi), 256'(0));
    end
    check("late_rv_done", 256'(bus.done), 256'(0));
    check("late_rv_nostart", 256'(start_cnt), 256'(s0));
    bus.cs = 1'b1;
    tick(6);
    check("post_rst_noerr", 256'(err_cnt), 256'(e0));
    run_frame(tbl[3], 128);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_aes_slave.md
SPI_AES_SLAVE -- requirements
Module: spi_aes_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk, cs, and mosi (minimum 2).
REQ-002 clk  input  1  system clock; every flop is clocked on the rising edge of clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 sclk  input  1  SPI bit clock from the master; asynchronous to clk; frequency at most clk/8.
REQ-005 cs  input  1  active-low chip select; the frame spans cs low to cs high.
REQ-006 mosi  input  1  serial data from the master; sampled on the sclk rising edge.
REQ-007 size  input  2  key length: 00=128, 01=192, 10=256, 11=illegal; captured at cs fall.
REQ-008 miso  output  1  serial result to the master; changes on the sclk falling edge.
REQ-009 msg  output  128  received message; bit i is the i-th received bit.
REQ-010 key  output  256  received key, left-justified; unused low bits are 0.
REQ-011 key_size  output  2  captured size, valid while start is asserted.
REQ-012 start  output  1  one-clk pulse to the AES core when msg and key are complete.
REQ-013 result  input  128  result from the AES core.
REQ-014 result_valid  input  1  one-clk pulse; result is valid in that cycle.
REQ-015 done  output  1  high once all 128 result bits have been shifted out.
REQ-016 frame_err  output  1  one-clk pulse on an aborted frame or an illegal size.

Function
REQ-017 sclk, cs, and mosi SHALL pass through SYNC_STAGES flops; sclk edges SHALL be detected by comparing the last two synchronized samples; all logic SHALL be sequential on clk.
REQ-018 FSM states: IDLE, RX_MSG, RX_KEY, START, WAIT_CORE, TX, DONE.
REQ-019 IDLE -> RX_MSG on the synchronized cs fall; size is captured; bit counter = 0; msg and key are cleared.
REQ-020 At cs fall with size=11, the FSM SHALL go IDLE -> DONE-less ERR path: pulse frame_err and stay IDLE until cs rises and falls again.
REQ-021 RX_MSG: each sclk rise SHALL write the mosi sample to msg[cnt] (LSB first) and increment cnt; after bit 127 the FSM goes to RX_KEY with cnt = 0.
REQ-022 RX_KEY: with N = 128/192/256, each sclk rise SHALL write mosi to key[256-N+cnt]; after bit N-1 the FSM goes to START.
REQ-023 START: start SHALL be high for exactly one clk, then the FSM goes to WAIT_CORE.
REQ-024 WAIT_CORE: on result_valid, result SHALL be latched into an internal shift register, miso SHALL be driven with result[0], and the FSM goes to TX with cnt = 0.
REQ-025 TX: each sclk fall SHALL advance to the next bit (LSB first).
    - After the fall that follows bit 127 has been held through an sclk rise, the FSM goes to DONE.
    - Total: 128 bits presented.
REQ-026 Outside TX, miso SHALL be driven 0.
REQ-027 DONE: done = 1; msg and key are held; the FSM returns to IDLE on cs rise, which clears done.
REQ-028 A cs rise in RX_MSG, RX_KEY, START, WAIT_CORE, or TX SHALL return the FSM to IDLE and pulse frame_err. A result_valid that arrives later SHALL be ignored.
REQ-029 result_valid outside WAIT_CORE SHALL be ignored.
REQ-030 sclk edges outside RX_MSG, RX_KEY, and TX SHALL have no effect.
REQ-031 cnt SHALL be 9 bits and SHALL never wrap; extra sclk edges in DONE SHALL be ignored.
REQ-032 A cs fall in the same cycle as the last TX bit edge: cs rise must precede it, so the FSM SHALL treat only edges in the legal order.
REQ-033 No new frame SHALL be accepted until the FSM is in IDLE.

Reset
REQ-034 reset low SHALL immediately force the following, asynchronously: state=IDLE, cnt=0, msg=0, key=0, shift register=0, miso=0, start=0, done=0, frame_err=0, size capture=00.
REQ-035 Synchronizer flops SHALL reset to the idle bus value: sclk=0, cs=1, mosi=0.
REQ-036 Reset deassertion mid-frame SHALL leave the FSM in IDLE until a fresh cs fall.

Verification
REQ-037 size=00, msg=3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c sent LSB first -> msg matches; key[255:128] matches and key[127:0]=0; one start pulse.
REQ-038 size=01, key 000102...1617 sent as 192 bits -> key[255:64] matches; key[63:0]=0; start after bit 320.
REQ-039 size=10, 256-bit key 0001...1e1f -> key matches; core returns result 3925841d02dc09fbdc118597196a0b32 -> 128 miso bits, LSB first, equal to result; done=1.
REQ-040 cs raised after 50 msg bits -> frame_err pulse; no start; state IDLE; the next full frame succeeds.
REQ-041 size=11 at cs fall -> frame_err pulse; no msg bits captured; no start.
REQ-042 reset asserted during TX at bit 60 -> miso=0 and done=0 immediately; a result_valid after release is ignored.
